exec_dispatch: RTL and testbench
================================

Name: exec_dispatch

Overview:
Parametrised execute-stage dispatcher for the multi-cycle core. It takes one decoded operation, drives the order/accepted/done handshake of one of N_UNIT functional units (alu, memory, fpu, io, …), captures that unit's result and presents a single-cycle writeback. It generalises the per-unit EXECUTE/EXECUTE_WAIT sequencing to an arbitrary unit count. It adds a per-operation timeout, error flags and performance counters.

Parameters:
N_UNIT, 4, number of functional-unit channels (>=1)
W_DATA, 32, result / writeback data width
W_RD, 6, destination register address width
TIMEOUT, 1024, max cycles in ISSUE+WAIT before abort; 0 disables timeout
W_CNT, 32, performance counter width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
req_valid  in  1  operation offered
req_ready  out  1  dispatcher can accept (high only in IDLE)
req_unit  in  N_UNIT  one-hot unit select
req_rd  in  W_RD  destination register
req_wb  in  1  operation writes a register (0 for store/output)
unit_order  out  N_UNIT  per-unit request flag
unit_accepted  in  N_UNIT  per-unit accept strobe
unit_done  in  N_UNIT  per-unit completion strobe
unit_result  in  N_UNIT*W_DATA  unit i result in bits [i*W_DATA +: W_DATA]
wb_valid  out  1  writeback pulse, one cycle
wb_en  out  1  register write enable qualifying wb_valid
wb_rd  out  W_RD  writeback register address
wb_data  out  W_DATA  writeback data
busy  out  1  high in ISSUE/WAIT/WB
err_timeout  out  1  sticky: an operation timed out
err_unit  out  1  sticky: req_unit was zero or not one-hot
err_clear  in  1  clears both sticky errors
cnt_issue  out  W_CNT  accepted requests, wraps
cnt_stall  out  W_CNT  cycles spent in ISSUE/WAIT, wraps

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; unit_order=0; wb_valid=0, wb_en=0, wb_rd=0, wb_data=0; err_*=0; counters=0; timer=0. Reset mid-operation abandons the op silently. The unit sees order drop and must tolerate this.
- States: IDLE, ISSUE, WAIT, WB. req_ready = (state==IDLE). busy = ~req_ready. wb_valid = (state==WB).
- IDLE, req_valid=1: latch sel=req_unit, rd=req_rd, wb=req_wb; cnt_issue+1; timer cleared.
  - sel one-hot: unit_order<=sel, go to ISSUE.
  - sel invalid: err_unit<=1, wb_en<=0, wb_data<=0, go to WB, no order issued.
- ISSUE (order high): timer+1, cnt_stall+1.
  - accepted[sel] or done[sel]: unit_order<=0.
  - done[sel]: wb_data<=result[sel], wb_en<=wb, go to WB. Done implies accept, even if accepted was never seen.
  - accepted[sel] without done[sel]: go to WAIT.
- WAIT (order low): timer+1, cnt_stall+1.
  - done[sel]: capture result, wb_en<=wb, go to WB.
- Timeout (TIMEOUT!=0): in ISSUE/WAIT, when timer==TIMEOUT-1 and done[sel]=0:
  - unit_order<=0, err_timeout<=1, wb_en<=0, wb_data<=0, go to WB.
  - A done on that same cycle wins over the timeout.
- WB: wb_valid=1 for exactly one cycle, wb_rd=latched rd, then go to IDLE.
- accepted/done/result from unselected units are ignored in all states. Done in IDLE/WB is ignored.
- Latency: request handshake at cycle T → unit_order high T+1. Accept+done at T+1 → wb_valid at T+2. Minimum issue interval is 3 cycles.
- err_clear: clears sticky bits. If a new error is set in the same cycle, set wins.
- Counters are unsigned and wrap modulo 2^W_CNT.
- At most one bit of unit_order is ever high.

Test Plan:
- N_UNIT=4, req_unit=0010, rd=5, wb=1; unit1 asserts accepted+done with result 0xDEADBEEF at T+1 → wb_valid at T+2, wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; unit_order=0010 for exactly one cycle.
- req_unit=0100, wb=0; accepted at T+2, done at T+6 with result 0x1234 → order high T+1..T+2, wb_valid at T+7 with wb_en=0; cnt_stall=6, cnt_issue=1.
- TIMEOUT=8, req_unit=0001, unit never accepts → order high 8 cycles then 0, wb_valid with wb_en=0, err_timeout=1. err_clear pulse → err_timeout=0. Repeat with done on the 8th cycle → normal writeback, err_timeout stays 0.
- req_unit=0000 and then 0110 → no unit_order toggles, each yields wb_valid with wb_en=0, err_unit=1, cnt_issue=2.
- Selected unit 2 busy, unit 3 pulses done with result 0xFFFF → ignored; unit 2 done with 0xAA → wb_data=0xAA.
- rstn low while in WAIT → next cycle state IDLE, unit_order=0, req_ready=1, counters=0, no wb_valid.

Source files
------------

// File: rtl/exec_dispatch_if.sv
// Dispatcher request, unit channel and writeback bundle.
// Master drives requests and unit responses; slave is the dispatcher.
interface exec_dispatch_if #(
  parameter int N_UNIT = 4,
  parameter int W_DATA = 32,
  parameter int W_RD   = 6
);
  logic                     req_valid;
  logic                     req_ready;
  logic [N_UNIT-1:0]        req_unit;
  logic [W_RD-1:0]          req_rd;
  logic                     req_wb;
  logic [N_UNIT-1:0]        unit_order;
  logic [N_UNIT-1:0]        unit_accepted;
  logic [N_UNIT-1:0]        unit_done;
  logic [N_UNIT*W_DATA-1:0] unit_result;
  logic                     wb_valid;
  logic                     wb_en;
  logic [W_RD-1:0]          wb_rd;
  logic [W_DATA-1:0]        wb_data;

  modport master (
    output req_valid, req_unit, req_rd, req_wb,
    output unit_accepted, unit_done, unit_result,
    input  req_ready, unit_order,
    input  wb_valid, wb_en, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_unit, req_rd, req_wb,
    input  unit_accepted, unit_done, unit_result,
    output req_ready, unit_order,
    output wb_valid, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/exec_dispatch.sv
// Execute-stage dispatcher: one op at a time to one of N_UNIT units,
// with timeout abort, sticky error flags and wrapping perf counters.
module exec_dispatch #(
  parameter int N_UNIT  = 4,
  parameter int W_DATA  = 32,
  parameter int W_RD    = 6,
  parameter int TIMEOUT = 1024,
  parameter int W_CNT   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  exec_dispatch_if.slave   bus,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_unit,
  input  logic             err_clear,
  output logic [W_CNT-1:0] cnt_issue,
  output logic [W_CNT-1:0] cnt_stall
);

  localparam int W_TMR =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_TMR-1:0] TMR_LAST =
    W_TMR'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_t;

  state_t             state_q, state_d;
  logic [N_UNIT-1:0]  sel_q, sel_d;
  logic [W_RD-1:0]    rd_q, rd_d;
  logic               wb_q, wb_d;
  logic [N_UNIT-1:0]  order_q, order_d;
  logic               wb_en_q, wb_en_d;
  logic [W_DATA-1:0]  wb_data_q, wb_data_d;
  logic               err_to_q, err_to_d;
  logic               err_un_q, err_un_d;
  logic [W_CNT-1:0]   cnt_iss_q, cnt_iss_d;
  logic [W_CNT-1:0]   cnt_stl_q, cnt_stl_d;
  logic [W_TMR-1:0]   tmr_q, tmr_d;

  logic               req_onehot;
  logic               acc_hit;
  logic               done_hit;
  logic               tmo_hit;
  logic               set_to;
  logic               set_un;
  logic [W_DATA-1:0]  res_sel;

  assign req_onehot = $onehot(bus.req_unit);
  assign acc_hit    = |(bus.unit_accepted & sel_q);
  assign done_hit   = |(bus.unit_done & sel_q);
  assign tmo_hit    = (TIMEOUT != 0) &&
                      (tmr_q == TMR_LAST);

  // Pick the latched unit's result slot; sel_q is one-hot here.
  always_comb begin
    res_sel = '0;
    for (int i = 0; i < N_UNIT; i++) begin
      if (sel_q[i]) begin
        res_sel = bus.unit_result[i*W_DATA +: W_DATA];
      end
    end
  end

  // Sequencing: next state, order line, capture and counters.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    wb_d      = wb_q;
    order_d   = order_q;
    wb_en_d   = wb_en_q;
    wb_data_d = wb_data_q;
    cnt_iss_d = cnt_iss_q;
    cnt_stl_d = cnt_stl_q;
    tmr_d     = tmr_q;
    set_to    = 1'b0;
    set_un    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          sel_d     = bus.req_unit;
          rd_d      = bus.req_rd;
          wb_d      = bus.req_wb;
          cnt_iss_d = cnt_iss_q + W_CNT'(1);
          tmr_d     = '0;
          if (req_onehot) begin
            order_d = bus.req_unit;
            state_d = S_ISSUE;
          end else begin
            set_un    = 1'b1;
            wb_en_d   = 1'b0;
            wb_data_d = '0;
            state_d   = S_WB;
          end
        end
      end

      S_ISSUE, S_WAIT: begin
        tmr_d     = tmr_q + W_TMR'(1);
        cnt_stl_d = cnt_stl_q + W_CNT'(1);
        if (done_hit) begin
          order_d   = '0;
          wb_data_d = res_sel;
          wb_en_d   = wb_q;
          state_d   = S_WB;
        end else if (tmo_hit) begin
          order_d   = '0;
          set_to    = 1'b1;
          wb_en_d   = 1'b0;
          wb_data_d = '0;
          state_d   = S_WB;
        end else if (state_q == S_ISSUE
                     && acc_hit) begin
          order_d = '0;
          state_d = S_WAIT;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky errors: a new error this cycle beats err_clear.
  always_comb begin
    err_to_d = set_to | (err_to_q & ~err_clear);
    err_un_d = set_un | (err_un_q & ~err_clear);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      rd_q      <= '0;
      wb_q      <= 1'b0;
      order_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      err_to_q  <= 1'b0;
      err_un_q  <= 1'b0;
      cnt_iss_q <= '0;
      cnt_stl_q <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wb_q      <= wb_d;
      order_q   <= order_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      err_to_q  <= err_to_d;
      err_un_q  <= err_un_d;
      cnt_iss_q <= cnt_iss_d;
      cnt_stl_q <= cnt_stl_d;
      tmr_q     <= tmr_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.unit_order = order_q;
  assign bus.wb_valid   = (state_q == S_WB);
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_rd      = rd_q;
  assign bus.wb_data    = wb_data_q;

  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_to_q;
  assign err_unit    = err_un_q;
  assign cnt_issue   = cnt_iss_q;
  assign cnt_stall   = cnt_stl_q;

endmodule

// File: tb/tb_exec_dispatch.sv
// Self-checking bench for exec_dispatch: directed scenarios plus
// randomized ops against a cycle-count outcome model.
module tb_exec_dispatch;

  localparam int NU  = 4;
  localparam int WD  = 32;
  localparam int WR  = 6;
  localparam int TO  = 8;
  localparam int WC  = 4;
  localparam int INF = 100000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          busy;
  logic          err_timeout;
  logic          err_unit;
  logic          err_clear;
  logic [WC-1:0] cnt_issue;
  logic [WC-1:0] cnt_stall;

  exec_dispatch_if #(.N_UNIT(NU), .W_DATA(WD), .W_RD(WR)) bus ();

  exec_dispatch #(
    .N_UNIT(NU), .W_DATA(WD), .W_RD(WR),
    .TIMEOUT(TO), .W_CNT(WC)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .busy(busy),
    .err_timeout(err_timeout),
    .err_unit(err_unit),
    .err_clear(err_clear),
    .cnt_issue(cnt_issue),
    .cnt_stall(cnt_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_issue;
  int m_stall;
  bit m_eto;
  bit m_eun;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid     = 1'b0;
    bus.req_unit      = '0;
    bus.req_rd        = '0;
    bus.req_wb        = 1'b0;
    bus.unit_accepted = '0;
    bus.unit_done     = '0;
    bus.unit_result   = '0;
    err_clear         = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    m_issue = 0;
    m_stall = 0;
    m_eto   = 1'b0;
    m_eun   = 1'b0;
  endtask

  // One operation: the unit accepts at cycle ka (0 = never) and
  // completes at cycle kd, counted from the first ISSUE cycle.
  task automatic run_op(
    input logic [NU-1:0] u,
    input logic [WR-1:0] rd,
    input bit            wb,
    input int            ka,
    input int            kd,
    input logic [WD-1:0] res,
    input bit            noise,
    input int            xu,
    input int            xk,
    input logic [WD-1:0] xres,
    input string         tag
  );
    bit              valid;
    int              ui;
    int              drop;
    int              end_c;
    bit              tmo;
    logic            e_en;
    logic [WD-1:0]   e_data;
    logic [NU-1:0]   e_ord;
    logic [NU-1:0]   acc;
    logic [NU-1:0]   dn;
    logic [NU*WD-1:0] ur;
    valid = $onehot(u);
    ui = 0;
    for (int i = 0; i < NU; i++) if (u[i]) ui = i;
    if (!valid) begin
      end_c = 0;
      drop  = 0;
      tmo   = 1'b0;
    end else begin
      end_c = (kd < TO) ? kd : TO;
      drop  = end_c;
      if (ka > 0 && ka < drop) drop = ka;
      tmo   = (kd > TO);
    end
    e_en   = valid && !tmo && wb;
    e_data = (valid && !tmo) ? res : '0;

    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready: got %b want 1", tag, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_unit  = u;
    bus.req_rd    = rd;
    bus.req_wb    = wb;
    tick();
    bus.req_valid = 1'b0;
    bus.req_unit  = '0;

    for (int c = 1; c <= end_c + 1; c++) begin
      e_ord = (valid && c <= drop) ? u : '0;
      n_checks++;
      if (bus.unit_order !== e_ord) begin
        n_fail++;
        $display("FAIL %s order c=%0d: got %b want %b",
                 tag, c, bus.unit_order, e_ord);
      end
      n_checks++;
      if (bus.wb_valid !== (c == end_c + 1)) begin
        n_fail++;
        $display("FAIL %s wb_valid c=%0d: got %b want %b",
                 tag, c, bus.wb_valid, (c == end_c + 1));
      end
      if (c == end_c + 1) begin
        n_checks++;
        if (bus.wb_en !== e_en) begin
          n_fail++;
          $display("FAIL %s wb_en: got %b want %b",
                   tag, bus.wb_en, e_en);
        end
        n_checks++;
        if (bus.wb_rd !== rd) begin
          n_fail++;
          $display("FAIL %s wb_rd: got %0d want %0d",
                   tag, bus.wb_rd, rd);
        end
        n_checks++;
        if (bus.wb_data !== e_data) begin
          n_fail++;
          $display("FAIL %s wb_data: got %h want %h",
                   tag, bus.wb_data, e_data);
        end
      end
      acc = '0;
      dn  = '0;
      ur  = '0;
      if (noise) begin
        acc = NU'($urandom) & ~u;
        dn  = NU'($urandom) & ~u;
        for (int i = 0; i < NU; i++) ur[i*WD +: WD] = $urandom;
      end
      if (valid) begin
        acc[ui] = (c == ka);
        dn[ui]  = (c == kd);
        if (c == kd) ur[ui*WD +: WD] = res;
      end
      if (xu >= 0 && c == xk) begin
        acc[xu] = 1'b1;
        dn[xu]  = 1'b1;
        ur[xu*WD +: WD] = xres;
      end
      bus.unit_accepted = acc;
      bus.unit_done     = dn;
      bus.unit_result   = ur;
      tick();
    end
    bus.unit_accepted = '0;
    bus.unit_done     = '0;
    bus.unit_result   = '0;

    m_issue += 1;
    m_stall += end_c;
    if (!valid) m_eun = 1'b1;
    if (tmo)    m_eto = 1'b1;

    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: got ready=%b wbv=%b want 1 0",
               tag, bus.req_ready, bus.wb_valid);
    end
    n_checks++;
    if (cnt_issue !== WC'(m_issue)) begin
      n_fail++;
      $display("FAIL %s cnt_issue: got %0d want %0d",
               tag, cnt_issue, WC'(m_issue));
    end
    n_checks++;
    if (cnt_stall !== WC'(m_stall)) begin
      n_fail++;
      $display("FAIL %s cnt_stall: got %0d want %0d",
               tag, cnt_stall, WC'(m_stall));
    end
    n_checks++;
    if (err_timeout !== m_eto || err_unit !== m_eun) begin
      n_fail++;
      $display("FAIL %s errors: got to=%b un=%b want to=%b un=%b",
               tag, err_timeout, err_unit, m_eto, m_eun);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset ready/busy: got %b %b want 1 0",
               bus.req_ready, busy);
    end
    n_checks++;
    if (bus.unit_order !== '0 || bus.wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset order/wbv: got %b %b want 0 0",
               bus.unit_order, bus.wb_valid);
    end
    n_checks++;
    if (bus.wb_en !== 1'b0 || bus.wb_rd !== '0 ||
        bus.wb_data !== '0) begin
      n_fail++;
      $display("FAIL reset wb: got en=%b rd=%0d d=%h want 0 0 0",
               bus.wb_en, bus.wb_rd, bus.wb_data);
    end
    n_checks++;
    if (err_timeout !== 1'b0 || err_unit !== 1'b0 ||
        cnt_issue !== '0 || cnt_stall !== '0) begin
      n_fail++;
      $display("FAIL reset err/cnt: got %b %b %0d %0d want 0 0 0 0",
               err_timeout, err_unit, cnt_issue, cnt_stall);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_op(4'b0010, 6'd5, 1'b1, 1, 1, 32'hDEADBEEF,
           1'b0, -1, 0, '0, "basic");
  endtask

  task automatic test_wait();
    do_reset();
    run_op(4'b0100, 6'd9, 1'b0, 2, 6, 32'h1234,
           1'b0, -1, 0, '0, "wait");
    n_checks++;
    if (cnt_stall !== WC'(6) || cnt_issue !== WC'(1)) begin
      n_fail++;
      $display("FAIL wait counts: got %0d %0d want 6 1",
               cnt_stall, cnt_issue);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_op(4'b0001, 6'd3, 1'b1, 0, INF, 32'h55,
           1'b0, -1, 0, '0, "timeout");
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    m_eto = 1'b0;
    m_eun = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", err_timeout);
    end
    run_op(4'b0001, 6'd4, 1'b1, 0, TO, 32'hCAFE0001,
           1'b0, -1, 0, '0, "done_at_limit");
  endtask

  task automatic test_bad_unit();
    do_reset();
    run_op(4'b0000, 6'd7, 1'b1, 1, 1, 32'h1,
           1'b1, -1, 0, '0, "unit_zero");
    run_op(4'b0110, 6'd8, 1'b1, 1, 1, 32'h2,
           1'b1, -1, 0, '0, "unit_multi");
    n_checks++;
    if (cnt_issue !== WC'(2) || err_unit !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_unit totals: got %0d %b want 2 1",
               cnt_issue, err_unit);
    end
  endtask

  task automatic test_clear_vs_set();
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_unit  = 4'b0000;
    err_clear     = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    err_clear     = 1'b0;
    n_checks++;
    if (err_unit !== 1'b1 || bus.wb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL set_beats_clear: got un=%b wbv=%b want 1 1",
               err_unit, bus.wb_valid);
    end
    tick();
    m_issue += 1;
    m_eun = 1'b1;
  endtask

  task automatic test_ignore_other();
    do_reset();
    run_op(4'b0100, 6'd12, 1'b1, 1, 4, 32'hAA,
           1'b0, 3, 2, 32'hFFFF, "ignore_other");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.req_valid = 1'b1;
    bus.req_unit  = 4'b0100;
    bus.req_rd    = 6'd2;
    bus.req_wb    = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    bus.unit_accepted = 4'b0100;
    tick();
    bus.unit_accepted = '0;
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    m_issue = 0;
    m_stall = 0;
    m_eto   = 1'b0;
    m_eun   = 1'b0;
    n_checks++;
    if (bus.unit_order !== '0 || bus.req_ready !== 1'b1 ||
        bus.wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait state: got ord=%b rdy=%b wbv=%b want 0 1 0",
               bus.unit_order, bus.req_ready, bus.wb_valid);
    end
    n_checks++;
    if (cnt_issue !== '0 || cnt_stall !== '0) begin
      n_fail++;
      $display("FAIL rst_wait cnt: got %0d %0d want 0 0",
               cnt_issue, cnt_stall);
    end
    bus.unit_done = 4'b0100;
    tick();
    bus.unit_done = '0;
    n_checks++;
    if (bus.wb_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait late done: got wbv=%b rdy=%b want 0 1",
               bus.wb_valid, bus.req_ready);
    end
  endtask

  task automatic test_random();
    logic [NU-1:0] u;
    int            r;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 7);
      if (r < 6)       u = NU'(1) << $urandom_range(0, NU - 1);
      else if (r == 6) u = '0;
      else             u = NU'($urandom);
      run_op(u, WR'($urandom), 1'($urandom),
             $urandom_range(0, 5), $urandom_range(1, 11),
             $urandom, 1'b1, -1, 0, '0, "random");
      if ($urandom_range(0, 3) == 0) begin
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        m_eto = 1'b0;
        m_eun = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    clear_inputs();
    rstn = 1'b1;
    test_reset();
    test_basic();
    test_wait();
    test_timeout();
    test_bad_unit();
    test_clear_vs_set();
    test_ignore_other();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
